// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder/loader: field formats, RV32I opcodes,
// loader FSM states and the signed-range helper used by the field packer.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // True when v is representable as a sign-extended value of the given width.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Pure combinational RV32I packer: scatters the immediate per format and flags
// illegal formats and immediates that do not fit the chosen format.
module instr_field_packer
  import instr_enc_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal,
  output logic        o_range_err
);

  always_comb begin
    o_word      = '0;
    o_illegal   = 1'b0;
    o_range_err = 1'b0;
    case (fmt_e'(i_fmt))
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_range_err = !sext_fits(i_imm, 12);
      end
      FMT_S: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_range_err = !sext_fits(i_imm, 12);
      end
      FMT_B: begin
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
        o_range_err = !sext_fits(i_imm, 13) || i_imm[0];
      end
      FMT_U: begin
        o_word      = {i_imm[31:12], i_rd, i_opcode};
        o_range_err = |i_imm[11:0];
      end
      FMT_J: begin
        o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_range_err = !sext_fits(i_imm, 21) || i_imm[0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into RV32I words, buffers them in a small FIFO
// and streams them to instruction memory. Define INSTR_ENC_RANGE_CHECK_EN to drop
// out-of-range immediates and raise the sticky err_o flag.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_last_i,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  localparam int unsigned   PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  logic [31:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_addr;
  logic             r_err;
  logic             r_done;
  state_e           r_state;
  state_e           w_state_next;
  logic             w_done_next;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_range_err;
  logic        w_empty, w_full, w_pop, w_accept, w_drop, w_push;

  instr_field_packer u_packer (
    .i_fmt       (fmt_i),
    .i_opcode    (opcode_i),
    .i_rd        (rd_i),
    .i_funct3    (funct3_i),
    .i_rs1       (rs1_i),
    .i_rs2       (rs2_i),
    .i_funct7    (funct7_i),
    .i_imm       (imm_i),
    .o_word      (w_word),
    .o_illegal   (w_illegal),
    .o_range_err (w_range_err)
  );

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = !w_empty && mem_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign in_ready_o = (r_state == ST_RUN) && (!w_full || w_pop);
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_drop     = w_illegal || (RANGE_EN && w_range_err);
  assign w_push     = w_accept && !w_drop;

  assign mem_we_o   = !w_empty;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_fifo[r_rd_ptr];
  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = r_done;
  assign err_o      = r_err;

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start_i) r_addr <= BASE_ADDR;
      else if (w_pop)                    r_addr <= r_addr + 32'd4;
      if (r_state == ST_IDLE && start_i)            r_err <= 1'b0;
      else if (RANGE_EN && w_accept && w_drop)      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_next = ST_RUN;
      ST_RUN:   if (w_accept && in_last_i) w_state_next = ST_DRAIN;
      // Leave as the final word is being accepted so done_o and !busy_o coincide.
      ST_DRAIN: if (w_empty || (r_count == CNT_ONE && w_pop)) begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: scoreboard of expected memory writes
// plus per-scenario tasks covering encodings, backpressure, done/busy and drops.
module tb_instr_encoder_loader;
  import instr_enc_pkg::*;

  localparam logic [31:0] TB_BASE = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        in_last_i = 1'b0;
  logic [2:0]  fmt_i = '0;
  logic [6:0]  opcode_i = '0;
  logic [4:0]  rd_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] imm_i = '0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ready_i = 1'b0;
  logic        busy_o, done_o, err_o;

  instr_encoder_loader #(.FIFO_DEPTH(4), .BASE_ADDR(TB_BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .in_last_i(in_last_i), .fmt_i(fmt_i), .opcode_i(opcode_i),
    .rd_i(rd_i), .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct7_i(funct7_i),
    .imm_i(imm_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] exp_addr = TB_BASE;
  logic        rand_ready = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr, hold_data;

  // Reference encoder built from shifts and masks.
  function automatic logic [31:0] model(input logic [2:0] fmt, input logic [6:0] opc,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] rdf, f3f, rs1f, rs2f;
    rdf  = 32'(rd) << 7;
    f3f  = 32'(f3) << 12;
    rs1f = 32'(rs1) << 15;
    rs2f = 32'(rs2) << 20;
    w    = 32'(opc);
    case (fmt)
      3'd0: w = w | rdf | f3f | rs1f | rs2f | (32'(f7) << 25);
      3'd1: w = w | rdf | f3f | rs1f | ((imm & 32'hFFF) << 20);
      3'd2: w = w | f3f | rs1f | rs2f | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      3'd3: w = w | f3f | rs1f | rs2f | (((imm >> 12) & 32'h1) << 31)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 32'h1) << 7);
      3'd4: w = w | rdf | (imm & 32'hFFFFF000);
      3'd5: w = w | rdf | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000FF000);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Scoreboard consumer: every accepted memory write must match the queue head,
  // and a stalled write must hold address and data until accepted.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== hold_addr || mem_data_o !== hold_data) begin
          failures++;
          $display("FAIL hold_stable: got we=%b addr=%h data=%h, need we=1 addr=%h data=%h",
                   mem_we_o, mem_addr_o, mem_data_o, hold_addr, hold_data);
        end
      end
      if (mem_we_o === 1'b1 && mem_ready_i === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%h data=%h, need no write",
                   mem_addr_o, mem_data_o);
        end else begin
          mon_e = sb_q.pop_front();
          if (mem_addr_o !== mon_e.addr || mem_data_o !== mon_e.data) begin
            failures++;
            $display("FAIL mem_write: got addr=%h data=%h, need addr=%h data=%h",
                     mem_addr_o, mem_data_o, mon_e.addr, mon_e.data);
          end else begin
            $display("write addr=%h data=%h", mem_addr_o, mem_data_o);
          end
        end
      end
      hold_pend = (mem_we_o === 1'b1) && (mem_ready_i !== 1'b1);
      hold_addr = mem_addr_o;
      hold_data = mem_data_o;
    end
  end

  always @(posedge clk_i) begin
    if (rand_ready) begin
      #1 mem_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    exp_addr = TB_BASE;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [6:0] f7, input logic [31:0] imm);
    fmt_i = fmt; opcode_i = opc; rd_i = rd; funct3_i = f3;
    rs1_i = rs1; rs2_i = rs2; funct7_i = f7; imm_i = imm;
  endtask

  // Offers the bundle already on the field inputs; queues the write if one is expected.
  task automatic send(input logic last, input logic exp_ok, input logic [31:0] exp_word);
    logic got;
    got = 1'b0;
    in_valid_i = 1'b1;
    in_last_i  = last;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk_i);
      if (in_ready_o === 1'b1) got = 1'b1;
      else begin
        @(posedge clk_i);
        #1;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL send_timeout: got in_ready_o=0 for 200 cycles, need 1");
    end else if (exp_ok) begin
      sb_q.push_back('{addr: exp_addr, data: exp_word});
      exp_addr = exp_addr + 32'd4;
    end
    if (got) begin
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_done_timeout: got done_o=0, need 1", tag);
    end else begin
      checks++;
      if (busy_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_at_done: got %b, need 0", tag, busy_o);
      end
      checks++;
      if (sb_q.size() != 0) begin
        failures++;
        $display("FAIL %s_pending_at_done: got %0d, need 0", tag, sb_q.size());
      end
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_done_pulse_width: got %b, need 0", tag, done_o);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({busy_o, done_o, err_o, mem_we_o, in_ready_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got busy/done/err/we/rdy=%b, need 00000",
               {busy_o, done_o, err_o, mem_we_o, in_ready_o});
    end
    checks++;
    if (mem_addr_o !== TB_BASE) begin
      failures++;
      $display("FAIL reset_addr: got %h, need %h", mem_addr_o, TB_BASE);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_not_ready: got rdy=%b busy=%b, need 0 0", in_ready_o, busy_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_encodings();
    mem_ready_i = 1'b1;
    do_start();
    // Unused fields carry junk that must not reach the packed word.
    set_fields(3'd1, OPC_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd7, 7'h7F, 32'd5);
    send(1'b0, 1'b1, 32'h00500093);
    set_fields(3'd2, OPC_STORE, 5'd0, 3'd2, 5'd0, 5'd2, 7'h00, 32'd8);
    send(1'b0, 1'b1, 32'h00202423);
    set_fields(3'd3, OPC_BRANCH, 5'd31, 3'd0, 5'd0, 5'd0, 7'h55, 32'hFFFF_FFFC);
    send(1'b0, 1'b1, 32'hFE000EE3);
    set_fields(3'd5, OPC_JAL, 5'd1, 3'd7, 5'd5, 5'd9, 7'h03, 32'd8);
    send(1'b1, 1'b1, 32'h008000EF);
    wait_done("encodings");
  endtask

  task automatic test_backpressure();
    int k;
    mem_ready_i = 1'b0;
    do_start();
    k = 0;
    in_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_fields(3'd1, OPC_OP_IMM, 5'(k + 1), 3'd0, 5'd3, 5'd0, 7'd0, 32'(k * 3));
      in_last_i = (k == 5);
      @(negedge clk_i);
      if (in_ready_o === 1'b1 && k < 6) begin
        sb_q.push_back('{addr: exp_addr, data: model(3'd1, OPC_OP_IMM, 5'(k + 1), 3'd0,
                                                      5'd3, 5'd0, 7'd0, 32'(k * 3))});
        exp_addr = exp_addr + 32'd4;
        k++;
      end
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    @(negedge clk_i);
    checks++;
    if (k != 4) begin
      failures++;
      $display("FAIL bp_accept_count: got %0d, need 4", k);
    end
    checks++;
    if (in_ready_o !== 1'b0 || mem_we_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_full_state: got rdy=%b we=%b, need 0 1", in_ready_o, mem_we_o);
    end
    @(posedge clk_i);
    #1 mem_ready_i = 1'b1;
    for (int j = 4; j < 6; j++) begin
      set_fields(3'd1, OPC_OP_IMM, 5'(j + 1), 3'd0, 5'd3, 5'd0, 7'd0, 32'(j * 3));
      send(j == 5, 1'b1, model(3'd1, OPC_OP_IMM, 5'(j + 1), 3'd0, 5'd3, 5'd0, 7'd0, 32'(j * 3)));
    end
    wait_done("backpressure");
  endtask

  task automatic test_done_pulse();
    mem_ready_i = 1'b1;
    do_start();
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL run_state: got busy=%b rdy=%b, need 1 1", busy_o, in_ready_o);
    end
    @(posedge clk_i);
    #1;
    for (int j = 0; j < 3; j++) begin
      set_fields(3'd0, OPC_OP, 5'(j + 4), 3'(j), 5'(j + 10), 5'(j + 20), 7'h20, 32'hDEAD_BEEF);
      send(j == 2, 1'b1, model(3'd0, OPC_OP, 5'(j + 4), 3'(j), 5'(j + 10), 5'(j + 20),
                              7'h20, 32'hDEAD_BEEF));
    end
    wait_done("three_words");
  endtask

  task automatic test_range_and_illegal();
    logic [31:0] b_word;
    mem_ready_i = 1'b1;
    do_start();
    b_word = 32'h00000163;
    set_fields(3'd3, OPC_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    send(1'b0, 1'b0, b_word);
`else
    send(1'b0, 1'b1, b_word);
`endif
    set_fields(3'd6, OPC_OP, 5'd1, 3'd1, 5'd1, 5'd1, 7'd1, 32'd0);
    send(1'b0, 1'b0, 32'h0);
    set_fields(3'd4, OPC_LUI, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    send(1'b1, 1'b1, 32'h12345337);
    wait_done("range");
    checks++;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b, need 1", err_o);
    end
    do_start();
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_clear_on_start: got %b, need 0", err_o);
    end
    set_fields(3'd1, OPC_OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    send(1'b1, 1'b1, 32'h00000013);
    wait_done("range_restart");
`else
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_disabled: got %b, need 0", err_o);
    end
`endif
  endtask

  task automatic test_random_stream();
    logic [2:0]  f;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    do_start();
    rand_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      f   = 3'($urandom_range(0, 5));
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3  = 3'($urandom); f7  = 7'($urandom); opc = 7'($urandom);
      // Keep immediates legal for every format so both build modes expect a write.
      case (f)
        3'd3:    imm = 32'($signed(13'($urandom)) & ~32'sd1);
        3'd4:    imm = $urandom & 32'hFFFFF000;
        3'd5:    imm = 32'($signed(21'($urandom)) & ~32'sd1);
        default: imm = 32'($signed(12'($urandom)));
      endcase
      set_fields(f, opc, rd, f3, rs1, rs2, f7, imm);
      send(j == 9, 1'b1, model(f, opc, rd, f3, rs1, rs2, f7, imm));
    end
    rand_ready = 1'b0;
    @(posedge clk_i);
    #2 mem_ready_i = 1'b1;
    wait_done("random");
  endtask

  task automatic test_reset_midop();
    mem_ready_i = 1'b0;
    do_start();
    for (int j = 0; j < 2; j++) begin
      set_fields(3'd1, OPC_OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'(j));
      send(1'b0, 1'b1, model(3'd1, OPC_OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'(j)));
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    sb_q.delete();
    @(negedge clk_i);
    checks++;
    if (mem_we_o !== 1'b0 || busy_o !== 1'b0 || mem_addr_o !== TB_BASE) begin
      failures++;
      $display("FAIL midop_reset: got we=%b busy=%b addr=%h, need 0 0 %h",
               mem_we_o, busy_o, mem_addr_o, TB_BASE);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    mem_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    do_start();
    set_fields(3'd5, OPC_JAL, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFF0);
    send(1'b1, 1'b1, model(3'd5, OPC_JAL, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFF0));
    wait_done("after_reset");
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_backpressure();
    test_done_pulse();
    test_range_and_illegal();
    test_random_stream();
    test_reset_midop();
    repeat (3) @(posedge clk_i);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: got %0d pending, need 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
